sdm_pattern_detector: RTL and testbench
=======================================

Name: sdm_pattern_detector

Overview:
- Parametrised successor to the fixed "1010" serial sequence detector.
- Detects a runtime-programmable bit pattern of 1..MAX_LEN bits in a serial stream, one bit per enabled clock.
- Overlap and non-overlap detection are selectable at runtime. A saturating match counter is provided.
- Sits directly on the serial input path in place of the fixed-pattern detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of the pattern-length field; must hold MAX_LEN.
- CNT_W, 8, match-counter width.
- DEFAULT_PATTERN, 8'b0000_1010, pattern loaded at reset (MAX_LEN bits).
- DEFAULT_LEN, 4, pattern length loaded at reset.
- DEFAULT_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset at the clock edge).
- enable  in  1  sample sequence_in on this edge.
- sequence_in  in  1  serial data bit.
- cfg_load  in  1  latch cfg_pattern, cfg_len and cfg_overlap on this edge.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- detector_out  out  1  one-cycle match pulse (registered).
- match_count  out  CNT_W  number of matches since reset or cfg_load.
- count_sat  out  1  match_count has saturated.

Behaviour:
- Reset (reset==0 at an edge):
  - history, fill, detector_out, match_count and count_sat are cleared to 0.
  - Active config is set to DEFAULT_PATTERN, DEFAULT_LEN and DEFAULT_OVERLAP.
  - Reset overrides every other input, including mid-stream: a partially received pattern is discarded.
- Internal state:
  - history is a MAX_LEN-bit shift register; the newest bit is at [0].
  - fill counts valid history bits and saturates at MAX_LEN.
- Length clamp, applied when cfg_len is latched:
  - cfg_len==0 is stored as 1.
  - cfg_len>MAX_LEN is stored as MAX_LEN.
- cfg_load=1 at an edge (reset inactive):
  - Latch the clamped config.
  - Clear history, fill, match_count, count_sat and detector_out.
  - Any enable on the same edge is ignored and the bit is discarded (load wins).
- enable=1 and cfg_load=0 at an edge:
  - Shift sequence_in into history[0] and increment fill.
  - Match condition: the new fill >= len AND the new history[len-1:0] == pattern[len-1:0].
  - On a match:
    - detector_out=1 for exactly the following cycle.
    - match_count increments.
    - In non-overlap mode, fill is cleared to 0, so the next match needs len fresh bits.
    - In overlap mode, fill is unchanged.
  - With no match, detector_out=0.
- enable=0:
  - history, fill and match_count hold.
  - detector_out=0; the pulse never stretches across idle cycles.
- Latency: detector_out rises on the same edge that samples the final pattern bit and is visible for one clock period after it.
- Counter saturation:
  - match_count stops at 2^CNT_W-1.
  - count_sat is set on the match that reaches saturation, and is sticky until reset or cfg_load.
  - detector_out still pulses on matches after saturation.
- Back-to-back matches (overlap mode, e.g. pattern 1 with len 1) give consecutive detector_out cycles.
- The pattern must not match until len bits have been received since reset, cfg_load or a non-overlap match. Stale history bits must never produce a match.

Test Plan:
- Default config, enable=1, stream 0,1,0,1,0,1,1,0,1,0,0 -> detector_out pulses after the 5th and 10th bits; match_count=2.
- Default pattern, overlap=1, stream 1,0,1,0,1,0 -> pulses after bits 4 and 6; count=2. Repeat with cfg_load overlap=0 -> pulse after bit 4 only; count=1.
- cfg_load pattern=3'b110 len=3, same edge enable=1 with sequence_in=1 -> that bit is discarded. Then stream 1,1,0,1,1,0 -> pulses after bits 3 and 6; count=2. cfg_len=0 -> len 1; cfg_len=15 -> len MAX_LEN.
- Enable gaps: bits 1,0, then enable=0 for 3 cycles with sequence_in=1, then bits 1,0 -> a single pulse after the last bit; detector_out=0 during the gap.
- Reset mid-operation: after bits 1,0,1, drive reset=0 for one edge, then bit 0 -> no pulse; count=0; config back to default.
- CNT_W=3, pattern len=1 pattern=1, overlap=1, 9 consecutive 1s -> 9 pulses; match_count=7; count_sat=1 from the 7th match.

Source files
------------

// File: rtl/sdm_pattern_detector.sv
// Serial pattern detector with a runtime-programmable pattern (1..MAX_LEN bits).
// It supports overlap and non-overlap matching and has a saturating match counter.
module sdm_pattern_detector #(
    parameter int unsigned        MAX_LEN         = 8,
    parameter int unsigned        LEN_W           = 4,
    parameter int unsigned        CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter logic [LEN_W-1:0]   DEFAULT_LEN     = LEN_W'(4),
    parameter logic               DEFAULT_OVERLAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sequence_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    always_comb begin
        len_clamp = cfg_len;
        if (cfg_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (cfg_len > MaxLen) begin
            len_clamp = MaxLen;
        end

        hist_shift = {history_q[MAX_LEN-2:0], sequence_in};
        fill_inc   = (fill_q == MaxLen) ? fill_q : fill_q + LEN_W'(1);
        // Only the low len bits of history take part in the compare.
        len_mask   = ~({MAX_LEN{1'b1}} << len_q);
        hit        = (fill_inc >= len_q) && (((hist_shift ^ pattern_q) & len_mask) == '0);

        history_d  = history_q;
        fill_d     = fill_q;
        det_d      = 1'b0;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = len_clamp;
            overlap_d = cfg_overlap;
            history_d = '0;
            fill_d    = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
        end else if (enable) begin
            history_d = hist_shift;
            fill_d    = fill_inc;
            if (hit) begin
                det_d = 1'b1;
                if (!overlap_q) begin
                    fill_d = '0;
                end
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CntMax - CNT_W'(1)) begin
                        sat_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            history_q <= '0;
            fill_q    <= '0;
            det_q     <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= DEFAULT_LEN;
            overlap_q <= DEFAULT_OVERLAP;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            det_q     <= det_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = cnt_q;
    assign count_sat    = sat_q;

endmodule

// File: tb/tb_sdm_pattern_detector.sv
// Directed bench for sdm_pattern_detector: expected pulses are queued as each bit is driven
// and compared after the edge; a second instance with a 3-bit counter covers saturation.
module tb_sdm_pattern_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sequence_in = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       detector_out, count_sat;
    logic [7:0] match_count;
    logic       det3, sat3;
    logic [2:0] cnt3;

    logic exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    sdm_pattern_detector dut (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .detector_out(detector_out), .match_count(match_count),
        .count_sat(count_sat)
    );

    sdm_pattern_detector #(.CNT_W(3)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .detector_out(det3), .match_count(cnt3),
        .count_sat(sat3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; the pulse expected after this edge goes via the queue.
    task automatic step(input logic en, input logic b, input logic exp_det, input string tag);
        logic e;
        enable      = en;
        sequence_in = b;
        exp_q.push_back(exp_det);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk(tag, {31'd0, detector_out}, {31'd0, e});
    endtask

    task automatic stream(input logic [31:0] bits, input logic [31:0] exps, input int n,
                          input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], exps[i], tag);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        enable      = 1'b1;
        sequence_in = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        chk("rst_det", {31'd0, detector_out}, 32'd0);
        chk("rst_cnt", {24'd0, match_count}, 32'd0);
        chk("rst_sat", {31'd0, count_sat}, 32'd0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic en, input logic b);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        step(en, b, 1'b0, "load_det");
        cfg_load = 1'b0;
        chk("load_cnt", {24'd0, match_count}, 32'd0);
        chk("load_cnt3", {29'd0, cnt3}, 32'd0);
        chk("load_sat3", {31'd0, sat3}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        @(posedge clock);
        do_reset();

        // Default 1010, overlap on
        stream(32'b01010110100, 32'b00001000010, 11, "dflt");
        chk("dflt_cnt", {24'd0, match_count}, 32'd2);

        do_reset();
        stream(32'b101010, 32'b000101, 6, "ovl");
        chk("ovl_cnt", {24'd0, match_count}, 32'd2);
        load(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
        stream(32'b101010, 32'b000100, 6, "novl");
        chk("novl_cnt", {24'd0, match_count}, 32'd1);

        // Load wins over a simultaneous enable
        load(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b1);
        stream(32'b110110, 32'b001001, 6, "p110");
        chk("p110_cnt", {24'd0, match_count}, 32'd2);
        load(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b1);
        stream(32'b10, 32'b00, 2, "discard");
        chk("discard_cnt", {24'd0, match_count}, 32'd0);

        // Length clamps
        load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0);
        stream(32'b0110, 32'b0110, 4, "len0");
        chk("len0_cnt", {24'd0, match_count}, 32'd2);
        load(8'b1011_0011, 4'd15, 1'b0, 1'b0, 1'b0);
        stream(32'b1011001110110011, 32'b0000000100000001, 16, "len15");
        chk("len15_cnt", {24'd0, match_count}, 32'd2);

        // Enable gaps hold history and never stretch the pulse
        do_reset();
        stream(32'b10, 32'b00, 2, "gap_a");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "gap_idle");
        stream(32'b10, 32'b01, 2, "gap_b");
        step(1'b0, 1'b0, 1'b0, "gap_after");
        chk("gap_cnt", {24'd0, match_count}, 32'd1);

        // Reset mid-stream discards history and restores the default config
        load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
        stream(32'b101, 32'b001, 3, "pre_rst");
        do_reset();
        step(1'b1, 1'b0, 1'b0, "post_rst");
        chk("post_rst_cnt", {24'd0, match_count}, 32'd0);
        stream(32'b1010, 32'b0001, 4, "rst_dflt");
        chk("rst_dflt_cnt", {24'd0, match_count}, 32'd1);

        // Saturation on the 3-bit counter instance
        load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b1, 1'b1, "sat_det");
            chk("sat_det3", {31'd0, det3}, 32'd1);
            chk("sat_cnt3", {29'd0, cnt3}, (k < 7) ? k : 7);
            chk("sat_flag3", {31'd0, sat3}, (k >= 7) ? 32'd1 : 32'd0);
        end
        chk("sat_cnt8", {24'd0, match_count}, 32'd9);
        chk("sat_flag8", {31'd0, count_sat}, 32'd0);
        load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
